// File: rtl/uart_pkg.sv
// Shared definitions for the UART link modules.
//   BYTE_W               : width of a transmitted byte
//   uart_tx_state_e      : transmit arbiter FSM states
//   UART_TIMEOUT_DEFAULT : default watchdog limit in pclk cycles
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam int unsigned UART_TIMEOUT_DEFAULT = 200000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
// Searches req upward from ptr, wrapping at NUM_REQ, and reports the first set bit.
//   req   : request vector
//   ptr   : search start index (must be < NUM_REQ)
//   valid : at least one request bit set
//   idx   : index of the winning request (0 when !valid)
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Wrap by subtraction so non-power-of-2 NUM_REQ works.
      pos = 32'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!valid && req[IDX_W'(pos)]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit byte path between NUM_REQ requesters.
// Round-robin arbitration, one-cycle tx_start strobe, waits for tx_done, then
// pulses req_ack for the winner. A watchdog aborts a transfer whose tx_done never
// arrives and sets the sticky timeout_err flag.
// Build option: UART_TX_FIXED_PRIORITY_EN -- requester 0 always wins when
// requesting; the others share round-robin among 1..NUM_REQ-1.
// Ports:
//   pclk, rst_n   : clock, synchronous active-low reset
//   req/req_data  : per-requester level request and byte (byte i at [8i+7:8i])
//   req_ack       : one-cycle pulse when the requester's byte is transmitted
//   tx_data       : byte to the transmitter, held outside transfers
//   tx_start      : one-cycle start strobe to the transmitter
//   tx_busy       : transmitter busy, blocks arbitration
//   tx_done       : one-cycle end-of-byte pulse from the transmitter
//   grant_id      : current/last granted requester
//   timeout_err   : sticky watchdog error, cleared by err_clr
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 2,
  parameter  int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_DEFAULT,
  localparam int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  uart_tx_state_e    state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [BYTE_W-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0] pick_req;
  logic              pick_valid, win_valid;
  logic [ID_W-1:0]   pick_idx, win_idx, next_rr;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .req   (pick_req),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef UART_TX_FIXED_PRIORITY_EN
  always_comb begin
    pick_req  = req & ~NUM_REQ'(1);
    win_valid = req[0] | pick_valid;
    win_idx   = req[0] ? '0 : pick_idx;
  end
`else
  always_comb begin
    pick_req  = req;
    win_valid = pick_valid;
    win_idx   = pick_idx;
  end
`endif

  assign next_rr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tx_start  = 1'b0;
    req_ack   = '0;

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid && !tx_busy) begin
          grant_d   = win_idx;
          tx_data_d = req_bytes[win_idx];
          state_d   = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // BUSY lasts at most TIMEOUT_CYCLES-1 cycles, so tx_start to abort is
        // TIMEOUT_CYCLES cycles. tx_done takes priority over expiry.
        if (tx_done) begin
          state_d = ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
          err_d   = 1'b1;
          rr_d    = next_rr;
          state_d = IDLE;
        end
      end
      ACK: begin
        req_ack[grant_q] = 1'b1;
        rr_d             = next_rr;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling edge of pclk.
module tb_uart_tx_arbiter;

  logic        pclk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        grant_id;
  logic        timeout_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next falling edge where tx_start is high.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!tx_start && n < 20);
    check(tag, tx_start, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
  endtask

  logic [7:0] exp_data [4];
  logic       exp_id   [4];
  logic [1:0] exp_ack  [4];
  logic [1:0] ack_seen;
  logic       start_seen;

  initial begin
`ifdef UART_TX_FIXED_PRIORITY_EN
    exp_data = '{8'h11, 8'h11, 8'h11, 8'h11};
    exp_id   = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_ack  = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_data = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ack  = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    err_clr  = 1'b0;

    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_grant", grant_id, 0);
    check("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge pclk);

    // 1: single request, one-cycle latency, ack after tx_done
    req = 2'b01;
    req_data = 16'h00A5;
    @(negedge pclk);
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_grant", grant_id, 0);
    @(negedge pclk);
    check("t1_start_1cyc", tx_start, 0);
    repeat (8) @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    check("t1_ack", req_ack, 2'b01);
    req = 2'b00;
    @(negedge pclk);
    check("t1_ack_1cyc", req_ack, 0);
    check("t1_hold_data", tx_data, 8'hA5);

    // 2: both requesting, alternating service order, 3-cycle restart gap
    do_reset();
    req = 2'b11;
    req_data = 16'h2211;
    wait_start("t2_first_start");
    for (int k = 0; k < 4; k++) begin
      check("t2_data", tx_data, exp_data[k]);
      check("t2_grant", grant_id, exp_id[k]);
      repeat (2) @(negedge pclk);
      tx_done = 1'b1;
      @(negedge pclk);
      tx_done = 1'b0;
      check("t2_ack", req_ack, exp_ack[k]);
      if (k == 3) req = 2'b00;
      @(negedge pclk);
      if (k < 3) check("t2_gap_idle", tx_start, 0);
      @(negedge pclk);
      if (k < 3) check("t2_restart", tx_start, 1);
    end

    // 3: tx_busy blocks arbitration
    tx_busy = 1'b1;
    req = 2'b01;
    req_data = 16'h005A;
    start_seen = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      start_seen |= tx_start;
    end
    check("t3_blocked", start_seen, 0);
    tx_busy = 1'b0;
    @(negedge pclk);
    check("t3_start", tx_start, 1);
    check("t3_data", tx_data, 8'h5A);
    repeat (2) @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    check("t3_ack", req_ack, 2'b01);
    req = 2'b00;
    @(negedge pclk);

    // 4: watchdog abort 16 cycles after tx_start, then err_clr
    req = 2'b01;
    req_data = 16'h003C;
    wait_start("t4_start");
    ack_seen = '0;
    repeat (15) begin
      @(negedge pclk);
      ack_seen |= req_ack;
    end
    check("t4_err_early", timeout_err, 0);
    @(negedge pclk);
    ack_seen |= req_ack;
    check("t4_err_set", timeout_err, 1);
    check("t4_no_ack", ack_seen, 0);
    req = 2'b00;
    @(negedge pclk);
    check("t4_idle", tx_start, 0);
    check("t4_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    check("t4_err_clr", timeout_err, 0);
    // stray tx_done outside BUSY must not ack
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    check("t4_stray_done", req_ack, 0);

    // 5: tx_done in the expiry cycle wins over the watchdog
    req = 2'b01;
    req_data = 16'h0077;
    @(negedge pclk);
    check("t5_start", tx_start, 1);
    repeat (15) @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    check("t5_ack", req_ack, 2'b01);
    check("t5_no_err", timeout_err, 0);
    req = 2'b00;
    @(negedge pclk);
    check("t5_no_err_after", timeout_err, 0);

    // 6: reset during BUSY abandons the transfer, rr pointer restarts at 0
    req = 2'b11;
    req_data = 16'h2211;
    wait_start("t6_start");
`ifdef UART_TX_FIXED_PRIORITY_EN
    check("t6_grant", grant_id, 0);
    check("t6_data", tx_data, 8'h11);
`else
    check("t6_grant", grant_id, 1);
    check("t6_data", tx_data, 8'h22);
`endif
    repeat (2) @(negedge pclk);
    rst_n = 1'b0;
    @(negedge pclk);
    check("t6_rst_data", tx_data, 0);
    check("t6_rst_grant", grant_id, 0);
    check("t6_rst_ack", req_ack, 0);
    check("t6_rst_start", tx_start, 0);
    check("t6_rst_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge pclk);
    check("t6_reserve_start", tx_start, 1);
    check("t6_reserve_grant", grant_id, 0);
    check("t6_reserve_data", tx_data, 8'h11);
    repeat (2) @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    check("t6_ack", req_ack, 2'b01);
    req = 2'b00;
    @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
